// File: rtl/ppg_phase_scheduler.sv
// PPG runtime phase scheduler: cycles RED / IR / DARK LED phases,
// settles, averages ADC samples and publishes one triple per frame.
module ppg_phase_scheduler #(
    parameter int SETTLE_CYC = 4,
    parameter int AVG_LOG2   = 3
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [6:0] red_dc_comp,
    input  logic [3:0] red_pga,
    input  logic [6:0] ir_dc_comp,
    input  logic [3:0] ir_pga,
    input  logic [3:0] led_drive_cfg,
    input  logic [7:0] ADC,
    output logic       LED_RED,
    output logic       LED_IR,
    output logic [3:0] LED_DRIVE,
    output logic [6:0] DC_Comp,
    output logic [3:0] PGA_Gain,
    output logic [7:0] red_value,
    output logic [7:0] ir_value,
    output logic [7:0] dark_value,
    output logic       clip,
    output logic       frame_valid,
    output logic       busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RED_SET = 3'd1;
    localparam logic [2:0] S_RED_ACQ = 3'd2;
    localparam logic [2:0] S_IR_SET  = 3'd3;
    localparam logic [2:0] S_IR_ACQ  = 3'd4;
    localparam logic [2:0] S_DK_SET  = 3'd5;
    localparam logic [2:0] S_DK_ACQ  = 3'd6;

    localparam int AW = 8 + AVG_LOG2;
    localparam logic [3:0] SET_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [3:0] ACQ_LAST = 4'((1 << AVG_LOG2) - 1);

    logic [2:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] acc_q, acc_d;
    logic          clipf_q, clipf_d;
    logic [7:0]    red_sh_q, red_sh_d;
    logic [7:0]    ir_sh_q, ir_sh_d;
    logic [6:0]    rdc_q, rdc_d;
    logic [3:0]    rpga_q, rpga_d;
    logic [6:0]    idc_q, idc_d;
    logic [3:0]    ipga_q, ipga_d;
    logic [3:0]    drv_q, drv_d;
    logic [7:0]    red_v_q, red_v_d;
    logic [7:0]    ir_v_q, ir_v_d;
    logic [7:0]    dark_v_q, dark_v_d;
    logic          clip_v_q, clip_v_d;
    logic          fv_q, fv_d;
    logic          led_red_q, led_red_d;
    logic          led_ir_q, led_ir_d;
    logic [3:0]    drive_q, drive_d;
    logic [6:0]    dc_q, dc_d;
    logic [3:0]    pga_q, pga_d;
    logic          busy_q, busy_d;

    logic [AW-1:0] sum;
    logic [7:0]    avg;
    logic          hit;
    logic          fin;
    logic          set_done;
    logic          start;

    // The last sample joins the sum combinationally so the
    // average is ready on the final ACQ edge.
    assign sum      = acc_q + AW'(ADC);
    assign avg      = 8'(sum >> AVG_LOG2);
    assign hit      = (ADC == 8'd0) || (ADC == 8'd255);
    assign fin      = (cnt_q == ACQ_LAST);
    assign set_done = (cnt_q == SET_LAST);

    // Phase sequencing, accumulation, settings latch and publishing.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        clipf_d  = clipf_q;
        red_sh_d = red_sh_q;
        ir_sh_d  = ir_sh_q;
        rdc_d    = rdc_q;
        rpga_d   = rpga_q;
        idc_d    = idc_q;
        ipga_d   = ipga_q;
        drv_d    = drv_q;
        red_v_d  = red_v_q;
        ir_v_d   = ir_v_q;
        dark_v_d = dark_v_q;
        clip_v_d = clip_v_q;
        fv_d     = 1'b0;
        start    = 1'b0;
        // Enable loss discards the frame, except on the final
        // DARK sample, which still publishes.
        if (state_q != S_IDLE && !enable &&
            !(state_q == S_DK_ACQ && fin)) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            acc_d    = '0;
            clipf_d  = 1'b0;
            red_sh_d = '0;
            ir_sh_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (enable) start = 1'b1;
                end
                S_RED_SET, S_IR_SET, S_DK_SET: begin
                    if (set_done) begin
                        state_d = state_q + 3'd1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_RED_ACQ, S_IR_ACQ, S_DK_ACQ: begin
                    acc_d   = sum;
                    clipf_d = clipf_q | hit;
                    cnt_d   = cnt_q + 4'd1;
                    if (fin) begin
                        cnt_d = '0;
                        acc_d = '0;
                        if (state_q == S_RED_ACQ) begin
                            red_sh_d = avg;
                            state_d  = S_IR_SET;
                        end else if (state_q == S_IR_ACQ) begin
                            ir_sh_d = avg;
                            state_d = S_DK_SET;
                        end else begin
                            red_v_d  = red_sh_q;
                            ir_v_d   = ir_sh_q;
                            dark_v_d = avg;
                            clip_v_d = clipf_q | hit;
                            fv_d     = 1'b1;
                            if (enable) begin
                                start = 1'b1;
                            end else begin
                                state_d  = S_IDLE;
                                clipf_d  = 1'b0;
                                red_sh_d = '0;
                                ir_sh_d  = '0;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (start) begin
                state_d = S_RED_SET;
                cnt_d   = '0;
                acc_d   = '0;
                clipf_d = 1'b0;
                rdc_d   = red_dc_comp;
                rpga_d  = red_pga;
                idc_d   = ir_dc_comp;
                ipga_d  = ir_pga;
                drv_d   = led_drive_cfg;
            end
        end
    end

    // Analog drive follows the next state and the frame settings.
    always_comb begin
        led_red_d = 1'b0;
        led_ir_d  = 1'b0;
        drive_d   = '0;
        dc_d      = '0;
        pga_d     = '0;
        busy_d    = (state_d != S_IDLE);
        unique case (state_d)
            S_RED_SET, S_RED_ACQ: begin
                led_red_d = 1'b1;
                drive_d   = drv_d;
                dc_d      = rdc_d;
                pga_d     = rpga_d;
            end
            S_IR_SET, S_IR_ACQ: begin
                led_ir_d = 1'b1;
                drive_d  = drv_d;
                dc_d     = idc_d;
                pga_d    = ipga_d;
            end
            default: ;
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            clipf_q   <= 1'b0;
            red_sh_q  <= '0;
            ir_sh_q   <= '0;
            rdc_q     <= '0;
            rpga_q    <= '0;
            idc_q     <= '0;
            ipga_q    <= '0;
            drv_q     <= '0;
            red_v_q   <= '0;
            ir_v_q    <= '0;
            dark_v_q  <= '0;
            clip_v_q  <= 1'b0;
            fv_q      <= 1'b0;
            led_red_q <= 1'b0;
            led_ir_q  <= 1'b0;
            drive_q   <= '0;
            dc_q      <= '0;
            pga_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            clipf_q   <= clipf_d;
            red_sh_q  <= red_sh_d;
            ir_sh_q   <= ir_sh_d;
            rdc_q     <= rdc_d;
            rpga_q    <= rpga_d;
            idc_q     <= idc_d;
            ipga_q    <= ipga_d;
            drv_q     <= drv_d;
            red_v_q   <= red_v_d;
            ir_v_q    <= ir_v_d;
            dark_v_q  <= dark_v_d;
            clip_v_q  <= clip_v_d;
            fv_q      <= fv_d;
            led_red_q <= led_red_d;
            led_ir_q  <= led_ir_d;
            drive_q   <= drive_d;
            dc_q      <= dc_d;
            pga_q     <= pga_d;
            busy_q    <= busy_d;
        end
    end

    assign LED_RED     = led_red_q;
    assign LED_IR      = led_ir_q;
    assign LED_DRIVE   = drive_q;
    assign DC_Comp     = dc_q;
    assign PGA_Gain    = pga_q;
    assign red_value   = red_v_q;
    assign ir_value    = ir_v_q;
    assign dark_value  = dark_v_q;
    assign clip        = clip_v_q;
    assign frame_valid = fv_q;
    assign busy        = busy_q;

endmodule

// File: doc/ppg_phase_scheduler.md
Name: ppg_phase_scheduler

Overview:
- Runtime LED/ADC time-multiplexing sequencer for the pulse-oximeter analog front end. It takes over once the settings search has finished.
- Cycles RED, IR and DARK (ambient) phases. For each phase it drives LED_RED/LED_IR, LED_DRIVE, DC_Comp and PGA_Gain from per-channel settings latched once per frame.
- In each phase it waits a settling interval, then averages 2^AVG_LOG2 ADC samples.
- Publishes a coherent red/IR/dark sample triple with a one-cycle frame_valid strobe for downstream SpO2 processing.

Parameters:
SETTLE_CYC, 4, cycles spent in each SETTLE state after outputs change, before sampling (legal range 1..15)
AVG_LOG2, 3, log2 of the number of ADC samples averaged per phase (legal range 0..4)

Ports:
CLK  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run request (settings search complete); level-sensitive
red_dc_comp  in  7  DC compensation code for RED phase
red_pga  in  4  PGA gain code for RED phase
ir_dc_comp  in  7  DC compensation code for IR phase
ir_pga  in  4  PGA gain code for IR phase
led_drive_cfg  in  4  LED drive current code
ADC  in  8  front-end ADC sample
LED_RED  out  1  red LED enable
LED_IR  out  1  IR LED enable
LED_DRIVE  out  4  LED drive code to analog
DC_Comp  out  7  DC compensation code to analog
PGA_Gain  out  4  PGA gain code to analog
red_value  out  8  averaged RED sample of last completed frame
ir_value  out  8  averaged IR sample of last completed frame
dark_value  out  8  averaged ambient sample of last completed frame
clip  out  1  some sample in the last completed frame was 0 or 255
frame_valid  out  1  one-cycle strobe: value outputs and clip just updated
busy  out  1  high in every state except IDLE

Behaviour:
- Reset and clock: rst_n is asynchronous and active-low; the clock is CLK. All state and outputs are registered.
- Reset values: state=IDLE. LED_RED, LED_IR, LED_DRIVE, DC_Comp and PGA_Gain are 0. red_value, ir_value and dark_value are 0. clip, frame_valid and busy are 0. Counters and accumulator are cleared.
- State sequence: IDLE -> RED_SETTLE -> RED_ACQ -> IR_SETTLE -> IR_ACQ -> DARK_SETTLE -> DARK_ACQ -> RED_SETTLE ...
- IDLE -> RED_SETTLE on the first rising edge with enable=1.
- DARK_ACQ -> RED_SETTLE if enable=1, else -> IDLE.
- Settings latch: red_dc_comp, red_pga, ir_dc_comp, ir_pga and led_drive_cfg are captured on every edge that enters RED_SETTLE. Input changes mid-frame have no effect until the next frame.
- Analog outputs change on the edge entering each SETTLE state and hold through the following ACQ state:
  - RED: LED_RED=1, LED_IR=0, LED_DRIVE=drive, DC_Comp=red_dc, PGA_Gain=red_pga.
  - IR: LED_RED=0, LED_IR=1, LED_DRIVE=drive, DC_Comp=ir_dc, PGA_Gain=ir_pga.
  - DARK: both LEDs 0, LED_DRIVE=0, DC_Comp=0, PGA_Gain=0.
  - IDLE: all analog outputs 0.
  - LED_RED and LED_IR are never both 1.
- SETTLE: stays exactly SETTLE_CYC cycles; no sampling.
- ACQ: stays exactly N=2^AVG_LOG2 cycles and samples ADC on each of its N rising edges into an (8+AVG_LOG2)-bit accumulator. The accumulator is cleared on entry to every SETTLE state.
- Phase average = (acc + final sample) >> AVG_LOG2, truncating. No overflow is possible.
- Phase length is SETTLE_CYC+N cycles; frame length is 3*(SETTLE_CYC+N). With defaults: 12 and 36 cycles.
- Shadow registers hold the red and IR averages. On the final DARK_ACQ edge, red_value, ir_value, dark_value and clip update together, and frame_valid=1 for exactly that following cycle.
- clip: sticky per frame over all ACQ samples (ADC==0 or ADC==255). It is published at frame end; its internal flag clears on the edge entering RED_SETTLE.
- enable drop mid-frame (any state other than IDLE): next edge -> IDLE with analog outputs 0. The frame is discarded: no frame_valid, shadows and accumulator cleared. Published value outputs hold their last values.
- enable=0 on the final DARK_ACQ edge: the frame still publishes (frame_valid=1), then the block goes to IDLE.
- Asynchronous reset mid-operation: immediate return to reset values, including the value outputs.

Test Plan:
1. Assert rst_n=0 mid-frame -> all outputs 0 immediately, busy=0, state IDLE.
2. Settings red_dc=20, red_pga=5, ir_dc=30, ir_pga=7, drive=10; enable=1 at edge 0; ADC=100 in RED_ACQ, 60 in IR_ACQ, 12 in DARK_ACQ -> phase outputs match the RED/IR/DARK settings; frame_valid pulses one cycle after edge 36 with red=100, ir=60, dark=12, clip=0; a second frame_valid follows 36 cycles later.
3. RED_ACQ ADC alternating 100/101 over 8 samples (sum 804) -> red_value=100, confirming truncation.
4. Change red_pga 5->9 during IR_ACQ of frame 1 -> PGA_Gain=5 until the edge entering frame 2 RED_SETTLE, then PGA_Gain=9.
5. Drop enable during IR_ACQ -> IDLE next edge, LEDs/DC/PGA=0, no frame_valid, value outputs keep prior frame; re-enable restarts at RED_SETTLE with a fresh settle count.
6. A single ADC=255 sample in DARK_ACQ of frame 1 -> clip=1 with frame 1 frame_valid; frame 2 with all samples in 1..254 -> clip=0.
